// File: rtl/fifo_wptr_full_pkg.sv
// Shared FIFO pointer helpers: pointer width and Gray/binary conversion.
// The read-side pointer block uses the same package.
package fifo_wptr_full_pkg;

  localparam int FIFO_ADDR_SIZE_DEF = 2;
  localparam int PTR_MAX_W          = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  // The pointer carries one extra wrap bit beyond the RAM address.
  function automatic int ptr_width(input int addr_size);
    return addr_size + 1;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side FIFO pointer bundle. almost_full exists only when
// FIFO_WPTR_ALMOST_FULL_EN is defined.
interface fifo_wptr_full_if
  import fifo_wptr_full_pkg::*;
#(
  parameter int FIFO_addr_size = FIFO_ADDR_SIZE_DEF
);
  localparam int PTR_W = ptr_width(FIFO_addr_size);

  logic                      w_en;
  logic [PTR_W-1:0]          rptr_gray;
  logic [FIFO_addr_size-1:0] w_addr;
  logic [PTR_W-1:0]          wptr_gray;
  logic                      full;
`ifdef FIFO_WPTR_ALMOST_FULL_EN
  logic                      almost_full;

  modport master (input w_en, rptr_gray, output w_addr, wptr_gray, full, almost_full);
  modport slave  (output w_en, rptr_gray, input w_addr, wptr_gray, full, almost_full);
`else
  modport master (input w_en, rptr_gray, output w_addr, wptr_gray, full);
  modport slave  (output w_en, rptr_gray, input w_addr, wptr_gray, full);
`endif

endinterface

// File: rtl/fifo_wptr_full_sync_2ff.sv
// Two-flop synchronizer for multi-bit Gray pointers crossing clock domains.
// Shared by the write-side and read-side pointer blocks.
module sync_2ff #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q1_q;
  logic [WIDTH-1:0] q2_q;

  // NOTE: reset is sampled on the clock edge, so it lives inside the
  // edge-triggered block rather than in its sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= d_i;
      q2_q <= q1_q;
    end
  end

  assign q_o = q2_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full-flag generator for an async FIFO.
// Optional almost_full output under FIFO_WPTR_ALMOST_FULL_EN.
module fifo_wptr_full
  import fifo_wptr_full_pkg::*;
#(
  parameter int FIFO_addr_size = FIFO_ADDR_SIZE_DEF,
  parameter int AF_MARGIN      = 1
) (
  input  logic               clk_w,
  input  logic               rst_w,
  fifo_wptr_full_if.master   bus
);

  localparam int PTR_W = ptr_width(FIFO_addr_size);

  if (FIFO_addr_size < 2) begin : g_bad_size
    $error("FIFO_addr_size must be at least 2");
  end
  if (AF_MARGIN < 1 || AF_MARGIN >= (2 ** FIFO_addr_size)) begin : g_bad_margin
    $error("AF_MARGIN must lie in 1 .. depth-1");
  end

  function automatic logic [PTR_W-1:0] to_gray(input logic [PTR_W-1:0] b);
    ptr_t t;
    t = bin2gray(ptr_t'(b));
    return t[PTR_W-1:0];
  endfunction

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wgray_q, wgray_d;
  logic [PTR_W-1:0] rq2;
  logic             full_q, full_d;
  logic             w_inc;

  sync_2ff #(.WIDTH(PTR_W)) u_sync_rptr (
    .clk   (clk_w),
    .rst_n (rst_w),
    .d_i   (bus.rptr_gray),
    .q_o   (rq2)
  );

  // Full when the next write pointer equals the synchronized read pointer
  // with its two top Gray bits inverted (exactly one lap ahead).
  always_comb begin
    w_inc   = bus.w_en & ~full_q;
    wbin_d  = wbin_q + PTR_W'(w_inc);
    wgray_d = to_gray(wbin_d);
    full_d  = (wgray_d == {~rq2[PTR_W-1:PTR_W-2], rq2[PTR_W-3:0]});
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the pointer/flag stay mutually coherent.
  always_ff @(posedge clk_w) begin
    if (!rst_w) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
    end
  end

  assign bus.w_addr    = wbin_q[FIFO_addr_size-1:0];
  assign bus.wptr_gray = wgray_q;
  assign bus.full      = full_q;

`ifdef FIFO_WPTR_ALMOST_FULL_EN
  localparam logic [PTR_W:0] DEPTH_W  = (PTR_W+1)'(2 ** FIFO_addr_size);
  localparam logic [PTR_W:0] MARGIN_W = (PTR_W+1)'(AF_MARGIN);

  function automatic logic [PTR_W-1:0] to_bin(input logic [PTR_W-1:0] g);
    ptr_t t;
    t = gray2bin(ptr_t'(g));
    return t[PTR_W-1:0];
  endfunction

  logic [PTR_W-1:0] rbin_s;
  logic [PTR_W-1:0] level;
  logic [PTR_W:0]   free_cnt;
  logic             af_q, af_d;

  always_comb begin
    rbin_s   = to_bin(rq2);
    level    = wbin_d - rbin_s;
    free_cnt = DEPTH_W - {1'b0, level};
    af_d     = (free_cnt <= MARGIN_W);
  end

  always_ff @(posedge clk_w) begin
    if (!rst_w) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_d;
    end
  end

  assign bus.almost_full = af_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (depth 4): directed vector table,
// hand sequences for wrap/almost-full, and randomized traffic vs a count model.
module tb_fifo_wptr_full;

  localparam int A     = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 1;

  logic clk_w = 1'b0;
  logic rst_w = 1'b0;

  fifo_wptr_full_if #(.FIFO_addr_size(A)) bus ();

  fifo_wptr_full #(.FIFO_addr_size(A), .AF_MARGIN(AF)) dut (
    .clk_w (clk_w),
    .rst_w (rst_w),
    .bus   (bus.master)
  );

  always #5 clk_w = ~clk_w;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: counts of accepted writes and read-pointer positions as integers.
  int m_wcnt = 0;
  int m_rq1  = 0;
  int m_rq2  = 0;
  bit m_full = 1'b0;
  bit m_af   = 1'b0;

  function automatic logic [2:0] gray_of(input int n);
    int b;
    b = n % (2 * DEPTH);
    return 3'(b ^ (b >> 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst_n, input bit wen, input int rd);
    int occ;
    if (!rst_n) begin
      m_wcnt = 0; m_rq1 = 0; m_rq2 = 0; m_full = 1'b0; m_af = 1'b0;
    end else begin
      if (wen && !m_full) m_wcnt++;
      occ    = m_wcnt - m_rq2;
      m_full = (occ == DEPTH);
      m_af   = ((DEPTH - occ) <= AF);
      m_rq2  = m_rq1;
      m_rq1  = rd;
    end
  endtask

  task automatic step(input bit rst_n, input bit wen, input int rd);
    @(negedge clk_w);
    rst_w         = rst_n;
    bus.w_en      = wen;
    bus.rptr_gray = gray_of(rd);
    @(posedge clk_w);
    model_edge(rst_n, wen, rd);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".w_addr"},    32'(bus.w_addr),    32'(m_wcnt % DEPTH));
    check({tag, ".wptr_gray"}, 32'(bus.wptr_gray), 32'(gray_of(m_wcnt)));
    check({tag, ".full"},      32'(bus.full),      32'(m_full));
`ifdef FIFO_WPTR_ALMOST_FULL_EN
    check({tag, ".almost_full"}, 32'(bus.almost_full), 32'(m_af));
`endif
  endtask

  typedef struct {
    bit       rst_n;
    bit       w_en;
    int       rd;
    logic [1:0] exp_addr;
    logic [2:0] exp_gray;
    bit       exp_full;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd;
    bit rn, we;

    bus.w_en      = 1'b0;
    bus.rptr_gray = '0;

    // Reset with w_en high, fill, overflow, drain release, refill.
    vecs[0]  = '{1'b0, 1'b1, 0, 2'd0, 3'b000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 0, 2'd0, 3'b000, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 0, 2'd1, 3'b001, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 0, 2'd2, 3'b011, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 0, 2'd3, 3'b010, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 0, 2'd0, 3'b110, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 0, 2'd0, 3'b110, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 0, 2'd0, 3'b110, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 0, 2'd0, 3'b110, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1, 2'd0, 3'b110, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1, 2'd0, 3'b110, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1, 2'd0, 3'b110, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1, 2'd1, 3'b111, 1'b1};

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst_n, vecs[i].w_en, vecs[i].rd);
      check($sformatf("vec%0d.w_addr", i),    32'(bus.w_addr),    32'(vecs[i].exp_addr));
      check($sformatf("vec%0d.wptr_gray", i), 32'(bus.wptr_gray), 32'(vecs[i].exp_gray));
      check($sformatf("vec%0d.full", i),      32'(bus.full),      32'(vecs[i].exp_full));
    end

    // Wrap: eight writes with the read pointer trailing by one.
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, i);
      check($sformatf("wrap%0d.full", i), 32'(bus.full), 32'd0);
      check_model($sformatf("wrap%0d", i));
    end
    check("wrap.gray_home", 32'(bus.wptr_gray), 32'd0);
    check("wrap.addr_home", 32'(bus.w_addr),    32'd0);

`ifdef FIFO_WPTR_ALMOST_FULL_EN
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 0);
    step(1'b1, 1'b1, 0);
    check("af2.almost_full", 32'(bus.almost_full), 32'd0);
    step(1'b1, 1'b1, 0);
    check("af3.almost_full", 32'(bus.almost_full), 32'd1);
    check("af3.full",        32'(bus.full),        32'd0);
    step(1'b1, 1'b1, 0);
    check("af4.almost_full", 32'(bus.almost_full), 32'd1);
    check("af4.full",        32'(bus.full),        32'd1);
`endif

    // Randomized traffic with occasional mid-run resets.
    step(1'b0, 1'b0, 0);
    rd = 0;
    for (int i = 0; i < 500; i++) begin
      rn = ($urandom_range(0, 99) != 0);
      we = ($urandom_range(0, 9) < 7);
      if (!rn) begin
        rd = 0;
      end else if (rd < m_wcnt && $urandom_range(0, 1) == 1) begin
        rd++;
      end
      step(rn, we, rd);
      check_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
